// File: rtl/alu_sequencer.sv
// alu_sequencer: accepts one ALU request at a time, drives a shared ALU,
// handles multi-cycle ALU ops and runs unsigned restoring division on the ALU.
module alu_sequencer #(
    parameter int unsigned MCP_CYCLES = 2,
    parameter int unsigned DIV_BITS   = 32
) (
    input  logic        clk,
    input  logic        reset_b,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [5:0]  req_opcode,
    input  logic [31:0] req_a,
    input  logic [31:0] req_b,
    input  logic        req_cin,
    input  logic        req_vin,
    input  logic        flush,
    output logic [5:0]  alu_opcode,
    output logic [31:0] alu_a,
    output logic [31:0] alu_b,
    output logic        alu_cin,
    output logic        alu_vin,
    input  logic [31:0] alu_dout,
    input  logic        alu_cout,
    input  logic        alu_vout,
    input  logic        alu_mcp,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_data,
    output logic        rsp_c,
    output logic        rsp_v,
    output logic        busy
);

    // Opcode encodings shared with the cpu_2432 instruction set
    localparam logic [5:0] OP_MOV = 6'h00;
    localparam logic [5:0] OP_SUB = 6'h02;
    localparam logic [5:0] OP_DIV = 6'h04;

    typedef enum logic [2:0] {
        IDLE, EXEC, MCP_WAIT, DIV_LOOP, DONE
    } state_t;

    state_t      state;
    logic [2:0]  mcnt;
    logic [4:0]  dcnt;
    logic [31:0] dvd;
    logic [30:0] quo;
    logic        rem_msb;
    logic        div_take;
    logic [31:0] rem_next;

    // Restoring-divide step: a set remainder MSB means the shifted value
    // exceeds 32 bits, so it is always >= divisor and must be subtracted.
    always_comb begin
        div_take = !alu_cout || rem_msb;
        rem_next = div_take ? alu_dout : alu_a;
    end

    // Sequencer state, ALU drive and response registers
    always_ff @(posedge clk or negedge reset_b) begin
        if (!reset_b) begin
            state      <= IDLE;
            req_ready  <= 1'b1;
            busy       <= 1'b0;
            rsp_valid  <= 1'b0;
            rsp_data   <= '0;
            rsp_c      <= 1'b0;
            rsp_v      <= 1'b0;
            alu_opcode <= OP_MOV;
            alu_a      <= '0;
            alu_b      <= '0;
            alu_cin    <= 1'b0;
            alu_vin    <= 1'b0;
            mcnt       <= '0;
            dcnt       <= '0;
            dvd        <= '0;
            quo        <= '0;
            rem_msb    <= 1'b0;
        end else if (flush && state != IDLE) begin
            state      <= IDLE;
            req_ready  <= 1'b1;
            busy       <= 1'b0;
            rsp_valid  <= 1'b0;
            alu_opcode <= OP_MOV;
            alu_a      <= '0;
            alu_b      <= '0;
            alu_cin    <= 1'b0;
            alu_vin    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        req_ready <= 1'b0;
                        busy      <= 1'b1;
                        if (req_opcode == OP_DIV) begin
                            if (req_b == 32'd0) begin
                                state     <= DONE;
                                rsp_valid <= 1'b1;
                                rsp_data  <= 32'hFFFF_FFFF;
                                rsp_c     <= req_cin;
                                rsp_v     <= 1'b1;
                            end else begin
                                state      <= DIV_LOOP;
                                alu_opcode <= OP_SUB;
                                alu_a      <= {31'd0, req_a[31]};
                                alu_b      <= req_b;
                                dvd        <= {req_a[30:0], 1'b0};
                                rem_msb    <= 1'b0;
                                quo        <= '0;
                                dcnt       <= '0;
                            end
                        end else begin
                            state      <= EXEC;
                            alu_opcode <= req_opcode;
                            alu_a      <= req_a;
                            alu_b      <= req_b;
                            alu_cin    <= req_cin;
                            alu_vin    <= req_vin;
                        end
                    end
                end
                EXEC, MCP_WAIT: begin
                    if (state == EXEC && alu_mcp) begin
                        state <= MCP_WAIT;
                        mcnt  <= '0;
                    end else if (state == MCP_WAIT && mcnt != 3'(MCP_CYCLES - 1)) begin
                        mcnt <= mcnt + 3'd1;
                    end else begin
                        state      <= DONE;
                        rsp_valid  <= 1'b1;
                        rsp_data   <= alu_dout;
                        rsp_c      <= alu_cout;
                        rsp_v      <= alu_vout;
                        alu_opcode <= OP_MOV;
                        alu_a      <= '0;
                        alu_b      <= '0;
                        alu_cin    <= 1'b0;
                        alu_vin    <= 1'b0;
                    end
                end
                DIV_LOOP: begin
                    rem_msb <= rem_next[31];
                    dvd     <= {dvd[30:0], 1'b0};
                    quo     <= {quo[29:0], div_take};
                    dcnt    <= dcnt + 5'd1;
                    if (dcnt == 5'(DIV_BITS - 1)) begin
                        state      <= DONE;
                        rsp_valid  <= 1'b1;
                        rsp_data   <= {quo, div_take};
                        rsp_c      <= |rem_next;
                        rsp_v      <= 1'b0;
                        alu_opcode <= OP_MOV;
                        alu_a      <= '0;
                        alu_b      <= '0;
                    end else begin
                        alu_a <= {rem_next[30:0], dvd[31]};
                    end
                end
                DONE: begin
                    if (rsp_ready) begin
                        state     <= IDLE;
                        rsp_valid <= 1'b0;
                        req_ready <= 1'b1;
                        busy      <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_sequencer.sv
// tb_alu_sequencer: directed and randomized checks of alu_sequencer against a
// transaction-level model, with a behavioural ALU stub answering the DUT.
module tb_alu_sequencer;

    localparam int unsigned MCP = 2;
    localparam int unsigned DB  = 32;

    localparam logic [5:0] OP_MOV = 6'h00;
    localparam logic [5:0] OP_ADD = 6'h01;
    localparam logic [5:0] OP_SUB = 6'h02;
    localparam logic [5:0] OP_MUL = 6'h03;
    localparam logic [5:0] OP_DIV = 6'h04;
    localparam logic [5:0] OP_AND = 6'h05;

    logic        clk = 1'b0;
    logic        reset_b;
    logic        req_valid, req_ready;
    logic [5:0]  req_opcode;
    logic [31:0] req_a, req_b;
    logic        req_cin, req_vin, flush;
    logic [5:0]  alu_opcode;
    logic [31:0] alu_a, alu_b, alu_dout;
    logic        alu_cin, alu_vin, alu_cout, alu_vout, alu_mcp;
    logic        rsp_valid, rsp_ready, rsp_c, rsp_v, busy;
    logic [31:0] rsp_data;

    alu_sequencer #(.MCP_CYCLES(MCP), .DIV_BITS(DB)) dut (
        .clk(clk), .reset_b(reset_b),
        .req_valid(req_valid), .req_ready(req_ready), .req_opcode(req_opcode),
        .req_a(req_a), .req_b(req_b), .req_cin(req_cin), .req_vin(req_vin),
        .flush(flush),
        .alu_opcode(alu_opcode), .alu_a(alu_a), .alu_b(alu_b),
        .alu_cin(alu_cin), .alu_vin(alu_vin),
        .alu_dout(alu_dout), .alu_cout(alu_cout), .alu_vout(alu_vout), .alu_mcp(alu_mcp),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
        .rsp_c(rsp_c), .rsp_v(rsp_v), .busy(busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    int n_chk = 0;
    int n_fail = 0;

    // ALU reference: returns {carry/borrow, overflow, data}
    function automatic logic [33:0] alu_f(input logic [5:0] op, input logic [31:0] a, b,
                                          input logic cin, vin);
        logic [32:0] s;
        logic [63:0] p;
        logic [31:0] d;
        logic        c, v;
        d = b; c = cin; v = vin;
        case (op)
            OP_ADD: begin
                s = {1'b0, a} + {1'b0, b};
                d = s[31:0]; c = s[32];
                v = (a[31] == b[31]) && (d[31] != a[31]);
            end
            OP_SUB: begin
                s = {1'b0, a} - {1'b0, b};
                d = s[31:0]; c = s[32];
                v = (a[31] != b[31]) && (d[31] != a[31]);
            end
            OP_MUL: begin
                p = 64'(a) * 64'(b);
                d = p[31:0]; c = |p[63:32]; v = ^p[31:0];
            end
            OP_AND: d = a & b;
            default: ;
        endcase
        return {c, v, d};
    endfunction

    // A multiply result changes every cycle so the capture cycle is observable
    function automatic logic [31:0] noise_of(input int c);
        return 32'(c) * 32'h9E37_79B9;
    endfunction

    logic [33:0] alu_r;
    always_comb begin
        alu_r    = alu_f(alu_opcode, alu_a, alu_b, alu_cin, alu_vin);
        alu_dout = alu_r[31:0] ^ ((alu_opcode == OP_MUL) ? noise_of(cyc) : 32'd0);
        alu_cout = alu_r[33];
        alu_vout = alu_r[32];
    end

    // Transaction model: ph 0 = idle, 1 = working, 2 = result waiting
    int          ph = 0;
    int          k = 0;
    int          done_at = -1;
    logic        m_div;
    logic [5:0]  m_op;
    logic [31:0] m_a, m_b, e_data;
    logic        m_cin, m_vin, e_c, e_v;
    logic        rel_pending = 1'b0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at cycle %0d: got %h, want %h", nm, cyc, act, exp);
        end
    endtask

    // One clock cycle: compare outputs with the model, drive inputs, advance the model
    task automatic step(input logic v, input logic [5:0] op, input logic [31:0] a, b,
                        input logic cin, vin, fl, rdy, mcp);
        logic [63:0] a64, rem, sh;
        logic [5:0]  x_op;
        logic [31:0] x_a, x_b;
        logic        x_cin, x_vin;
        logic [33:0] r;
        int          i, cap;
        @(negedge clk);
        cyc++;
        chk("req_ready", 32'(req_ready), 32'(ph == 0));
        chk("busy", 32'(busy), 32'(ph != 0));
        chk("rsp_valid", 32'(rsp_valid), 32'(ph == 2));
        if (ph == 2) begin
            chk("rsp_data", rsp_data, e_data);
            chk("rsp_c", 32'(rsp_c), 32'(e_c));
            chk("rsp_v", 32'(rsp_v), 32'(e_v));
        end
        x_op = OP_MOV; x_a = '0; x_b = '0; x_cin = 1'b0; x_vin = 1'b0;
        if (ph == 1 && m_div) begin
            i    = cyc - k - 1;
            a64  = 64'(m_a);
            rem  = (a64 >> (32 - i)) % 64'(m_b);
            sh   = rem * 64'd2 + ((a64 >> (31 - i)) & 64'd1);
            x_op = OP_SUB; x_a = sh[31:0]; x_b = m_b;
        end else if (ph == 1) begin
            x_op = m_op; x_a = m_a; x_b = m_b; x_cin = m_cin; x_vin = m_vin;
        end
        chk("alu_opcode", 32'(alu_opcode), 32'(x_op));
        chk("alu_a", alu_a, x_a);
        chk("alu_b", alu_b, x_b);
        chk("alu_cin", 32'(alu_cin), 32'(x_cin));
        chk("alu_vin", 32'(alu_vin), 32'(x_vin));
        if (rel_pending) begin
            reset_b     = 1'b1;
            rel_pending = 1'b0;
        end
        req_valid = v; req_opcode = op; req_a = a; req_b = b;
        req_cin = cin; req_vin = vin; flush = fl; rsp_ready = rdy; alu_mcp = mcp;
        if (fl && ph != 0) begin
            ph = 0;
        end else if (ph == 0) begin
            if (v) begin
                k = cyc; m_op = op; m_a = a; m_b = b; m_cin = cin; m_vin = vin;
                m_div = (op == OP_DIV);
                done_at = -1;
                if (m_div && b == 32'd0) begin
                    ph = 2; e_data = 32'hFFFF_FFFF; e_c = cin; e_v = 1'b1;
                end else if (m_div) begin
                    ph = 1; done_at = cyc + 1 + int'(DB);
                    e_data = a / b; e_c = ((a % b) != 32'd0); e_v = 1'b0;
                end else begin
                    ph = 1;
                end
            end
        end else if (ph == 1) begin
            if (!m_div && cyc == k + 1) begin
                cap     = mcp ? cyc + int'(MCP) : cyc;
                done_at = cap + 1;
                r       = alu_f(m_op, m_a, m_b, m_cin, m_vin);
                e_data  = r[31:0] ^ ((m_op == OP_MUL) ? noise_of(cap) : 32'd0);
                e_c     = r[33];
                e_v     = r[32];
            end
            if (cyc + 1 == done_at) ph = 2;
        end else if (rdy) begin
            ph = 0;
        end
    endtask

    task automatic idle(input logic rdy, input logic mcp);
        step(1'b0, OP_MOV, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0, rdy, mcp);
    endtask

    // Reset asserted mid-cycle; released by the next step before its inputs apply
    task automatic reset_pulse();
        #2;
        reset_b = 1'b0;
        req_valid = 1'b0; flush = 1'b0; rsp_ready = 1'b0;
        #1;
        chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst_req_ready", 32'(req_ready), 32'd1);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_alu_opcode", 32'(alu_opcode), 32'(OP_MOV));
        chk("rst_rsp_data", rsp_data, 32'd0);
        ph = 0;
        rel_pending = 1'b1;
    endtask

    logic [5:0] ops [6] = '{OP_MOV, OP_ADD, OP_SUB, OP_MUL, OP_AND, OP_DIV};

    initial begin
        logic [31:0] dout_last, ra, rb;
        int          n_sub;
        reset_b = 1'b0;
        req_valid = 1'b0; req_opcode = OP_MOV; req_a = '0; req_b = '0;
        req_cin = 1'b0; req_vin = 1'b0; flush = 1'b0; rsp_ready = 1'b0; alu_mcp = 1'b0;
        repeat (2) @(negedge clk);
        chk("init_req_ready", 32'(req_ready), 32'd1);
        chk("init_alu_a", alu_a, 32'd0);
        chk("init_rsp_data", rsp_data, 32'd0);
        rel_pending = 1'b1;

        // ADD overflow, accepted on the first edge after reset release
        step(1'b1, OP_ADD, 32'h7FFF_FFFF, 32'd1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        idle(1'b0, 1'b0);
        chk("add_not_yet", 32'(rsp_valid), 32'd0);
        idle(1'b0, 1'b0);
        chk("add_valid", 32'(rsp_valid), 32'd1);
        chk("add_data", rsp_data, 32'h8000_0000);
        chk("add_v", 32'(rsp_v), 32'd1);
        chk("add_c", 32'(rsp_c), 32'd0);
        idle(1'b1, 1'b0);
        idle(1'b0, 1'b0);

        // MUL with multi-cycle flag
        step(1'b1, OP_MUL, 32'd3, 32'd5, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        idle(1'b0, 1'b1);
        idle(1'b0, 1'b0);
        idle(1'b0, 1'b0);
        #1;
        dout_last = alu_dout;
        chk("mul_not_yet", 32'(rsp_valid), 32'd0);
        idle(1'b0, 1'b0);
        chk("mul_valid", 32'(rsp_valid), 32'd1);
        chk("mul_data_last", rsp_data, dout_last);
        idle(1'b1, 1'b0);

        // DIV 100 / 7
        step(1'b1, OP_DIV, 32'd100, 32'd7, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        n_sub = 0;
        for (int j = 0; j < int'(DB); j++) begin
            idle(1'b0, 1'b1);
            if (alu_opcode == OP_SUB) n_sub++;
        end
        chk("div_sub_cycles", 32'(n_sub), 32'd32);
        chk("div_not_yet", 32'(rsp_valid), 32'd0);
        idle(1'b0, 1'b0);
        chk("div_data", rsp_data, 32'd14);
        chk("div_c", 32'(rsp_c), 32'd1);
        chk("div_v", 32'(rsp_v), 32'd0);
        idle(1'b1, 1'b0);

        // DIV by zero
        step(1'b1, OP_DIV, 32'd5, 32'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        idle(1'b0, 1'b0);
        chk("div0_valid", 32'(rsp_valid), 32'd1);
        chk("div0_data", rsp_data, 32'hFFFF_FFFF);
        chk("div0_v", 32'(rsp_v), 32'd1);
        chk("div0_c", 32'(rsp_c), 32'd1);
        idle(1'b1, 1'b0);

        // Flush during iteration 10, then an immediate new request
        step(1'b1, OP_DIV, 32'd1000, 32'd3, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        repeat (10) idle(1'b0, 1'b0);
        step(1'b0, OP_MOV, 32'd0, 32'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        step(1'b1, OP_ADD, 32'd2, 32'd3, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("flush_idle", 32'(busy), 32'd0);
        idle(1'b0, 1'b0);
        chk("flush_next_busy", 32'(busy), 32'd1);
        idle(1'b0, 1'b0);
        chk("flush_next_data", rsp_data, 32'd5);
        idle(1'b1, 1'b0);

        // Result held in DONE, then reset
        step(1'b1, OP_ADD, 32'd10, 32'd20, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        repeat (6) idle(1'b0, 1'b0);
        chk("hold_valid", 32'(rsp_valid), 32'd1);
        reset_pulse();
        idle(1'b0, 1'b0);
        idle(1'b0, 1'b0);
        chk("post_rst_ready", 32'(req_ready), 32'd1);

        // Randomized traffic
        for (int t = 0; t < 3000; t++) begin
            if ($urandom_range(0, 599) == 0) reset_pulse();
            ra = ($urandom_range(0, 1) == 0) ? $urandom : 32'($urandom_range(0, 5000));
            case ($urandom_range(0, 3))
                0:       rb = 32'd0;
                1:       rb = 32'($urandom_range(1, 255));
                default: rb = $urandom;
            endcase
            step($urandom_range(0, 9) < 7, ops[$urandom_range(0, 5)], ra, rb,
                 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                 $urandom_range(0, 39) == 0, 1'($urandom_range(0, 1)),
                 1'($urandom_range(0, 1)));
        end
        idle(1'b1, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/alu_sequencer.md
ALU_SEQUENCER -- requirements
Module: alu_sequencer

Interface
REQ-001 The block SHALL have parameter MCP_CYCLES, default 2, the extra hold cycles granted when the ALU asserts mcp_out; legal range 1..7.
REQ-002 The block SHALL have parameter DIV_BITS, default 32, the quotient bits produced by the iterative divide; legal range 1..32.
REQ-003 The block SHALL have these ports, one line each as name, direction, width, meaning:
- clk  in  1  sole clock; all state changes on the rising edge.
- reset_b  in  1  asynchronous, active-low reset.
- req_valid  in  1  request present.
- req_ready  out  1  sequencer can accept a request.
- req_opcode  in  6  opcode, using the cpu_2432.vh encodings.
- req_a  in  32  operand A.
- req_b  in  32  operand B.
- req_cin  in  1  carry flag in.
- req_vin  in  1  overflow flag in.
- flush  in  1  abort the current operation.
- alu_opcode  out  6  opcode driven to the ALU.
- alu_a  out  32  ALU operand A.
- alu_b  out  32  ALU operand B.
- alu_cin  out  1  ALU carry in.
- alu_vin  out  1  ALU overflow in.
- alu_dout  in  32  ALU result.
- alu_cout  in  1  ALU carry out.
- alu_vout  in  1  ALU overflow out.
- alu_mcp  in  1  ALU multi-cycle flag.
- rsp_valid  out  1  result present.
- rsp_ready  in  1  consumer accepts the result.
- rsp_data  out  32  result data.
- rsp_c  out  1  carry result.
- rsp_v  out  1  overflow result.
- busy  out  1  high in any state other than IDLE.

Function
REQ-004 The block SHALL implement the states IDLE, EXEC, MCP_WAIT, DIV_LOOP and DONE, and SHALL assert req_ready only in IDLE.
REQ-005 A request SHALL be accepted on a cycle with req_valid=1 and req_ready=1; the operands, flags and opcode SHALL then be registered and the state SHALL become EXEC, or DIV_LOOP when req_opcode is `DIV.
REQ-006 In EXEC and MCP_WAIT, alu_opcode, alu_a, alu_b, alu_cin and alu_vin SHALL be driven only from the registered values and SHALL stay stable.
REQ-007 In EXEC, if alu_mcp=0 the block SHALL capture alu_dout, alu_cout and alu_vout into the rsp registers and go to DONE.
- Result: rsp_valid rises 2 cycles after the accepting edge.
REQ-008 In EXEC, if alu_mcp=1 the block SHALL go to MCP_WAIT, hold there exactly MCP_CYCLES cycles, capture the ALU outputs in the last MCP_WAIT cycle, then go to DONE.
- Result: rsp_valid rises 2+MCP_CYCLES cycles after acceptance.
REQ-009 `DIV SHALL be unsigned restoring division of A by B, with the ALU reused as the subtractor.
- Each DIV_LOOP cycle: alu_opcode=`SUB, alu_a={rem[30:0], dividend_msb}, alu_b=divisor.
- If alu_cout=0 (no borrow), the remainder takes alu_dout and the quotient bit is 1; otherwise the remainder takes the shifted value and the quotient bit is 0.
REQ-010 DIV_LOOP SHALL run exactly DIV_BITS cycles, then go to DONE with rsp_data=quotient, rsp_c=(remainder!=0), rsp_v=0.
REQ-011 `DIV with B=0 SHALL skip iteration and go directly to DONE with rsp_data=32'hFFFFFFFF, rsp_c=cin and rsp_v=1.
REQ-012 In DONE the block SHALL hold rsp_valid=1 with stable rsp_data, rsp_c and rsp_v until rsp_ready=1, then return to IDLE on that edge.
- No request is accepted in the same cycle; the minimum spacing between accepts is 3 cycles.
REQ-013 flush=1 in any non-IDLE state SHALL force IDLE on the next edge, drop the result, and leave rsp_valid=0; flush=1 in IDLE SHALL have no effect.
REQ-014 If flush=1 and rsp_ready=1 coincide in DONE, flush SHALL win and the result SHALL count as not delivered.
REQ-015 alu_mcp SHALL be sampled only in EXEC and ignored in every other state.
REQ-016 In IDLE and DONE, all alu_* outputs SHALL be driven to 0, with alu_opcode=`MOV.

Reset
REQ-017 While reset_b=0, the block SHALL asynchronously enter IDLE and clear every output to 0: rsp_valid=0, busy=0, rsp_data=0, rsp_c=0, rsp_v=0, alu_a=0, alu_b=0.
- Exceptions: req_ready=1 and alu_opcode=`MOV.
REQ-018 Reset asserted mid-operation (MCP_WAIT, DIV_LOOP or DONE) SHALL abandon the operation, and the block SHALL produce no response after reset release.
REQ-019 The first request SHALL be accepted on the first rising edge after reset_b deasserts.

Verification
REQ-020 The bench SHALL cover the following directed scenarios:
- `ADD A=32'h7FFFFFFF, B=1, alu_mcp=0 -> rsp_valid 2 cycles after accept; rsp_data=32'h80000000, rsp_v=1, rsp_c=0.
- `MUL with alu_mcp=1, MCP_CYCLES=2 -> operands stable for 3 cycles; rsp_valid at cycle 4; rsp_data equals alu_dout from the final MCP_WAIT cycle.
- `DIV A=100, B=7 -> 32 DIV_LOOP cycles with alu_opcode=`SUB; rsp_data=14, rsp_c=1, rsp_v=0.
- `DIV A=5, B=0 -> DONE 1 cycle after accept; rsp_data=32'hFFFFFFFF, rsp_v=1.
- `DIV accepted, flush at iteration 10 -> IDLE next edge; rsp_valid never rises; the next request is accepted immediately.
- rsp_ready held low 5 cycles in DONE, then reset_b pulsed low -> rsp_valid drops asynchronously to 0; req_ready=1 after release.
